// File: rtl/uart_core_param.sv
// Parametrised UART transceiver with internal oversample tick generator,
// runtime parity select, frame/parity error flags and internal loopback.
module uart_core_param #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           parity_mode,
    input  logic                 loopback,
    input  logic                 tx_data_avail,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_active,
    output logic                 tx_done,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_avail,
    output logic                 parity_error,
    output logic                 frame_error
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int TCNT_W = $clog2(STOP_BITS * OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TCNT_W-1:0] OS_LAST   = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [TCNT_W-1:0] HALF_LAST = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] STOP_LAST = TCNT_W'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Free-running oversample tick shared by TX and RX
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    state_e                tx_state_q;
    logic [TCNT_W-1:0]     tx_cnt_q;
    logic [BIT_W-1:0]      tx_bit_q;
    logic [DATA_BITS-1:0]  tx_shift_q;
    logic                  tx_pen_q;
    logic                  tx_par_q;
    logic                  tx_serial_q;
    logic                  tx_active_q;
    logic                  tx_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_pen_q    <= 1'b0;
            tx_par_q    <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            unique case (tx_state_q)
                S_IDLE: begin
                    if (tx_data_avail) begin
                        tx_shift_q  <= tx_data;
                        tx_pen_q    <= ^parity_mode;
                        tx_par_q    <= (^tx_data) ^ parity_mode[1];
                        tx_cnt_q    <= '0;
                        tx_serial_q <= 1'b0;
                        tx_active_q <= 1'b1;
                        tx_state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tx_cnt_q == OS_LAST) begin
                            tx_cnt_q    <= '0;
                            tx_bit_q    <= '0;
                            tx_serial_q <= tx_shift_q[0];
                            tx_state_q  <= S_DATA;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (tx_cnt_q == OS_LAST) begin
                            tx_cnt_q <= '0;
                            if (tx_bit_q == BIT_LAST) begin
                                if (tx_pen_q) begin
                                    tx_serial_q <= tx_par_q;
                                    tx_state_q  <= S_PARITY;
                                end else begin
                                    tx_serial_q <= 1'b1;
                                    tx_state_q  <= S_STOP;
                                end
                            end else begin
                                tx_bit_q    <= tx_bit_q + 1'b1;
                                tx_shift_q  <= tx_shift_q >> 1;
                                tx_serial_q <= tx_shift_q[1];
                            end
                        end else begin
                            tx_cnt_q <= tx_cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        if (tx_cnt_q == OS_LAST) begin
                            tx_cnt_q    <= '0;
                            tx_serial_q <= 1'b1;
                            tx_state_q  <= S_STOP;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (tx_cnt_q == STOP_LAST) begin
                            tx_cnt_q    <= '0;
                            tx_serial_q <= 1'b1;
                            tx_active_q <= 1'b0;
                            tx_done_q   <= 1'b1;
                            tx_state_q  <= S_IDLE;
                        end else begin
                            tx_cnt_q <= tx_cnt_q + 1'b1;
                        end
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_active = tx_active_q;
    assign tx_done   = tx_done_q;

    logic rx_s1_q;
    logic rx_s2_q;
    logic rx_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_serial;
            rx_s2_q <= rx_s1_q;
        end
    end

    // Loopback taps the registered TX line after the synchroniser
    assign rx_line = loopback ? tx_serial_q : rx_s2_q;

    state_e                rx_state_q;
    logic [TCNT_W-1:0]     rx_cnt_q;
    logic [BIT_W-1:0]      rx_bit_q;
    logic [DATA_BITS-1:0]  rx_shift_q;
    logic                  rx_pen_q;
    logic                  rx_odd_q;
    logic                  rx_par_q;
    logic [DATA_BITS-1:0]  rx_data_q;
    logic                  rx_avail_q;
    logic                  rx_perr_q;
    logic                  rx_ferr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_pen_q   <= 1'b0;
            rx_odd_q   <= 1'b0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_avail_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_avail_q <= 1'b0;
            unique case (rx_state_q)
                S_IDLE: begin
                    if (!rx_line) begin
                        rx_cnt_q   <= '0;
                        rx_pen_q   <= ^parity_mode;
                        rx_odd_q   <= parity_mode[1];
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_cnt_q == HALF_LAST) begin
                            rx_cnt_q   <= '0;
                            rx_bit_q   <= '0;
                            rx_state_q <= rx_line ? S_IDLE : S_DATA;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (rx_cnt_q == OS_LAST) begin
                            rx_cnt_q   <= '0;
                            rx_shift_q <= {rx_line, rx_shift_q[DATA_BITS-1:1]};
                            if (rx_bit_q == BIT_LAST) begin
                                rx_state_q <= rx_pen_q ? S_PARITY : S_STOP;
                            end else begin
                                rx_bit_q <= rx_bit_q + 1'b1;
                            end
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        if (rx_cnt_q == OS_LAST) begin
                            rx_cnt_q   <= '0;
                            rx_par_q   <= rx_line;
                            rx_state_q <= S_STOP;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (rx_cnt_q == OS_LAST) begin
                            rx_cnt_q   <= '0;
                            rx_data_q  <= rx_shift_q;
                            rx_perr_q  <= rx_pen_q &
                                          ((^rx_shift_q) ^ rx_par_q ^ rx_odd_q);
                            rx_ferr_q  <= ~rx_line;
                            rx_avail_q <= 1'b1;
                            rx_state_q <= S_IDLE;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_avail = rx_avail_q;
    assign parity_error  = rx_perr_q;
    assign frame_error   = rx_ferr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: scoreboard of expected RX words,
// TX bit-slot sampling, latency windows, glitch and reset checks.
module tb_uart_core_param;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    logic [1:0] pm0, pm1;
    logic       lb0, lb1;
    logic       tx_avail0, tx_avail1;
    logic [7:0] tx_data0;
    logic [6:0] tx_data1;
    logic       tx_serial0, tx_serial1;
    logic       tx_active0, tx_active1;
    logic       tx_done0, tx_done1;
    logic       rx_serial0, rx_serial1;
    logic [7:0] rx_data0;
    logic [6:0] rx_data1;
    logic       rx_avail0, rx_avail1;
    logic       perr0, perr1;
    logic       ferr0, ferr1;

    exp_t q0[$];
    exp_t q1[$];
    int   rx1_t[$];
    int   rx0_cnt = 0;
    int   done0_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_core_param #(
        .DATA_BITS(8), .CLK_DIV(4), .OVERSAMPLE(16), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .rst(rst), .parity_mode(pm0), .loopback(lb0),
        .tx_data_avail(tx_avail0), .tx_data(tx_data0),
        .tx_serial(tx_serial0), .tx_active(tx_active0), .tx_done(tx_done0),
        .rx_serial(rx_serial0), .rx_data(rx_data0),
        .rx_data_avail(rx_avail0), .parity_error(perr0), .frame_error(ferr0)
    );

    uart_core_param #(
        .DATA_BITS(7), .CLK_DIV(4), .OVERSAMPLE(16), .STOP_BITS(2)
    ) dut1 (
        .clk(clk), .rst(rst), .parity_mode(pm1), .loopback(lb1),
        .tx_data_avail(tx_avail1), .tx_data(tx_data1),
        .tx_serial(tx_serial1), .tx_active(tx_active1), .tx_done(tx_done1),
        .rx_serial(rx_serial1), .rx_data(rx_data1),
        .rx_data_avail(rx_avail1), .parity_error(perr1), .frame_error(ferr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_done0) done0_cnt++;
        if (rx_avail0) begin
            rx0_cnt++;
            if (q0.size() == 0) begin
                chk("rx0_spurious", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("rx0_data", {24'd0, rx_data0}, {23'd0, e.d});
                chk("rx0_perr", {31'd0, perr0}, {31'd0, e.pe});
                chk("rx0_ferr", {31'd0, ferr0}, {31'd0, e.fe});
            end
        end
        if (rx_avail1) begin
            rx1_t.push_back(cyc);
            if (q1.size() == 0) begin
                chk("rx1_spurious", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("rx1_data", {25'd0, rx_data1}, {23'd0, e.d});
                chk("rx1_perr", {31'd0, perr1}, {31'd0, e.pe});
                chk("rx1_ferr", {31'd0, ferr1}, {31'd0, e.fe});
            end
        end
    end

    task automatic push0(input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [8:0] d);
        exp_t e;
        e.d = d; e.pe = 1'b0; e.fe = 1'b0;
        q1.push_back(e);
    endtask

    task automatic send0(input string tag, input logic [7:0] d, output int a);
        @(negedge clk);
        tx_avail0 = 1'b1;
        tx_data0  = d;
        @(posedge clk);
        #1;
        a = cyc;
        chk({tag, "_accept_active"}, {31'd0, tx_active0}, 1);
        chk({tag, "_accept_start"}, {31'd0, tx_serial0}, 0);
        tx_avail0 = 1'b0;
    endtask

    task automatic wait_done0(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk);
            if (tx_done0) at = cyc;
        end
        chk("tx0_done_seen", {31'd0, at >= 0}, 1);
    endtask

    task automatic drain0(input int budget);
        for (int i = 0; i < budget && q0.size() != 0; i++) @(negedge clk);
        chk("rx0_drain", q0.size(), 0);
    endtask

    task automatic drive_rx(input logic [8:0] d, input int nb, input bit pen,
                            input bit pb, input bit bad_stop);
        @(negedge clk);
        rx_serial0 = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx_serial0 = d[i];
            repeat (64) @(negedge clk);
        end
        if (pen) begin
            rx_serial0 = pb;
            repeat (64) @(negedge clk);
        end
        if (bad_stop) begin
            rx_serial0 = 1'b0;
            repeat (40) @(negedge clk);
        end
        rx_serial0 = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, d, n, nd, gap;
        logic [7:0] bits;
        rst = 1'b1;
        pm0 = 2'b00; pm1 = 2'b00;
        lb0 = 1'b0;  lb1 = 1'b1;
        tx_avail0 = 1'b0; tx_avail1 = 1'b0;
        tx_data0 = '0; tx_data1 = '0;
        rx_serial0 = 1'b1; rx_serial1 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_tx_serial", {31'd0, tx_serial0}, 1);
        chk("rst_tx_active", {31'd0, tx_active0}, 0);
        chk("rst_tx_done", {31'd0, tx_done0}, 0);
        chk("rst_rx_avail", {31'd0, rx_avail0}, 0);
        chk("rst_perr", {31'd0, perr0}, 0);
        chk("rst_ferr", {31'd0, ferr0}, 0);
        chk("rst_rx_data", {24'd0, rx_data0}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 1: loopback, even parity, 0x54
        pm0 = 2'b01; lb0 = 1'b1;
        push0(9'h54, 1'b0, 1'b0);
        send0("t1", 8'h54, a);
        repeat (9 * 64 + 32) @(negedge clk);
        chk("t1_parity_bit", {31'd0, tx_serial0}, 1);
        wait_done0(1500, d);
        chk("t1_done_window", {31'd0, (d - a) >= 700 && (d - a) <= 708}, 1);
        chk("t1_active_fall", {31'd0, tx_active0}, 0);
        drain0(200);
        lb0 = 1'b0;
        repeat (20) @(negedge clk);

        // 2: odd parity slot on TX, then bad parity on RX
        pm0 = 2'b10;
        send0("t2", 8'hAA, a);
        repeat (9 * 64 + 32) @(negedge clk);
        chk("t2_parity_bit", {31'd0, tx_serial0}, 1);
        wait_done0(1500, d);
        push0(9'h0AA, 1'b1, 1'b0);
        drive_rx(9'h0AA, 8, 1'b1, 1'b0, 1'b0);
        drain0(200);

        // 3: frame error then clean frame
        pm0 = 2'b00;
        push0(9'h03C, 1'b0, 1'b1);
        drive_rx(9'h03C, 8, 1'b0, 1'b0, 1'b1);
        drain0(200);
        repeat (100) @(negedge clk);
        push0(9'h05A, 1'b0, 1'b0);
        drive_rx(9'h05A, 8, 1'b0, 1'b0, 1'b0);
        drain0(200);

        // 4: start-bit glitch rejected
        n = rx0_cnt;
        rx_serial0 = 1'b0;
        repeat (16) @(negedge clk);
        rx_serial0 = 1'b1;
        repeat (200) @(negedge clk);
        chk("t4_no_avail", rx0_cnt, n);
        chk("t4_data_held", {24'd0, rx_data0}, 32'h5A);
        push0(9'h081, 1'b0, 1'b0);
        drive_rx(9'h081, 8, 1'b0, 1'b0, 1'b0);
        drain0(200);

        // 5: request while busy is dropped; reset mid-frame
        pm0 = 2'b01;
        nd = done0_cnt;
        send0("t5", 8'h54, a);
        repeat (10) @(negedge clk);
        tx_avail0 = 1'b1;
        tx_data0  = 8'h11;
        @(negedge clk);
        tx_avail0 = 1'b0;
        chk("t5_busy_active", {31'd0, tx_active0}, 1);
        repeat (20) @(negedge clk);
        chk("t5_start_bit", {31'd0, tx_serial0}, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk);
            bits[i] = tx_serial0;
        end
        chk("t5_data_bits", {24'd0, bits}, 32'h54);
        wait_done0(1000, d);
        repeat (200) @(negedge clk);
        chk("t5_no_second", {31'd0, tx_active0}, 0);
        chk("t5_done_once", done0_cnt - nd, 1);
        send0("t5r", 8'h54, a);
        repeat (300) @(negedge clk);
        nd = done0_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_serial", {31'd0, tx_serial0}, 1);
        chk("t5_rst_active", {31'd0, tx_active0}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (900) @(negedge clk);
        chk("t5_rst_no_done", done0_cnt, nd);
        chk("t5_rst_rx_data", {24'd0, rx_data0}, 0);

        // 6: 7 data bits, 2 stop bits, back-to-back in loopback
        push1(9'h07F);
        push1(9'h000);
        @(negedge clk);
        tx_avail1 = 1'b1;
        tx_data1  = 7'h7F;
        @(posedge clk);
        #1;
        tx_data1 = 7'h00;
        d = -1;
        for (int i = 0; i < 1000 && d < 0; i++) begin
            @(negedge clk);
            if (tx_done1) d = cyc;
        end
        chk("t6_first_done", {31'd0, d >= 0}, 1);
        @(posedge clk);
        #1;
        tx_avail1 = 1'b0;
        chk("t6_second_accept", {31'd0, tx_active1}, 1);
        for (int i = 0; i < 1500 && q1.size() != 0; i++) @(negedge clk);
        chk("t6_drain", q1.size(), 0);
        chk("t6_pulses", rx1_t.size(), 2);
        if (rx1_t.size() >= 2) begin
            gap = rx1_t[1] - rx1_t[0];
            chk("t6_gap_window", {31'd0, gap >= 636 && gap <= 644}, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_core_param.md
# uart_core_param

Parametrised UART transceiver: the next generation of the fixed 8-bit `uart_top`, for use wherever a serial console or link port is needed. It adds an internal baud/oversample generator, configurable data width and stop bits, and runtime-selectable parity (none/even/odd). It reports frame errors in addition to parity errors, rejects glitches on the start bit, and has an internal loopback mode for self-test. All logic runs on one clock with no external `clk_tick`.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9, sent LSB first.
- `CLK_DIV`, 27: `clk` cycles per oversample tick, ≥2.
- `OVERSAMPLE`, 16: ticks per bit, even, ≥4.
- `STOP_BITS`, 1: stop bits transmitted, 1 or 2.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `loopback` in 1: 1 routes the internal TX line to the RX path and ignores `rx_serial`.
- `tx_data_avail` in 1: request to send `tx_data`; sampled only when idle.
- `tx_data` in DATA_BITS: byte to transmit.
- `tx_serial` out 1: serial output, idle high; still driven in loopback.
- `tx_active` out 1: high while a frame is in flight.
- `tx_done` out 1: one-cycle pulse at the end of the last stop bit.
- `rx_serial` in 1: asynchronous serial input.
- `rx_data` out DATA_BITS: last received word, held until the next frame completes.
- `rx_data_avail` out 1: one-cycle pulse when `rx_data` and the error flags update.
- `parity_error` out 1: parity mismatch on the last frame; always 0 when parity is none.
- `frame_error` out 1: stop bit sampled low on the last frame.

## Operation
- Reset values: `tx_serial`=1; `tx_active`, `tx_done`, `rx_data_avail`, `parity_error`, `frame_error`=0; `rx_data`=0.
- Reset also clears the tick counter and both RX synchroniser flops (to 1). A reset mid-frame aborts both directions, and `tx_serial`=1 on the first cycle after reset.
- Tick generator: free-running counter 0..CLK_DIV-1. `tick` asserts for one cycle when the count equals CLK_DIV-1.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if parity is none) → STOP → IDLE.
  - IDLE: `tx_data_avail`=1 captures `tx_data` and `parity_mode`, then moves to START.
  - Each state lasts OVERSAMPLE ticks per bit; STOP lasts STOP_BITS×OVERSAMPLE ticks.
  - Parity bit: even = XOR of the data bits; odd = its inverse.
  - `tx_data_avail` while `tx_active`=1 is ignored; there is no queueing.
- RX path: `rx_serial` passes through a 2-flop synchroniser; the mux for `loopback` sits after the synchroniser.
- RX FSM states: IDLE → START → DATA → PARITY (optional) → STOP → IDLE.
  - IDLE: synchronised line = 0 moves to START, resets the tick count, and latches `parity_mode`.
  - START: after OVERSAMPLE/2 ticks, re-sample the line. If it is 1 (glitch), return to IDLE with no output. Otherwise proceed.
  - Each following bit is sampled every OVERSAMPLE ticks, i.e. at mid-bit.
  - STOP: sample the first stop bit only. In the same cycle, update `rx_data`, `parity_error` and `frame_error`, pulse `rx_data_avail`, and go to IDLE.
  - `rx_data`, `parity_error` and `frame_error` are updated regardless of error status and hold until the next completion or reset.
- A `parity_mode` change mid-frame affects only later frames. A `loopback` change mid-frame is legal; the current frame result is undefined.
- TX and RX run fully concurrently and independently.

## Timing
- Bit period T = CLK_DIV×OVERSAMPLE clk cycles.
- Frame length F = 1 + DATA_BITS + (1 if parity is on, else 0) + STOP_BITS bits.
- TX acceptance: `tx_active`=1 and `tx_serial`=0 on the cycle after `tx_data_avail` is sampled. The start bit may be short by up to CLK_DIV-1 cycles because the tick is free-running.
- `tx_done` pulse and the fall of `tx_active` occur in the same cycle, F×T (−CLK_DIV+1..0) cycles after acceptance. A new request is accepted in the cycle after `tx_done`.
- RX detect latency is 2 cycles (synchroniser). `rx_data_avail` fires about (F − STOP_BITS + 0.5)×T after the line falls, ±CLK_DIV + 2 cycles.
- RX is back in IDLE mid-stop-bit, so back-to-back frames with no idle gap are received without loss.

## Test plan
Default configuration for all scenarios: CLK_DIV=4, OVERSAMPLE=16, giving T=64 cycles.

1. `loopback`=1, even parity, send 0x54 → `rx_data_avail` pulse with `rx_data`=0x54, `parity_error`=0, `frame_error`=0. `tx_done` arrives 704±4 cycles after acceptance, and the parity bit on `tx_serial` is 1.
2. Odd parity, send 0xAA on `tx_serial` → the parity-bit slot on `tx_serial` reads 1. Bench then drives 0xAA on `rx_serial` with parity 0 → `rx_data`=0xAA, `parity_error`=1.
3. Bench drives a valid 0x3C frame with the stop bit low → `frame_error`=1, `rx_data`=0x3C. The next clean frame clears `frame_error` to 0.
4. Glitch rejection: `rx_serial` low for 16 cycles, then high → no `rx_data_avail`, and RX returns to IDLE. A following valid 0x81 frame is received correctly.
5. Pulse `tx_data_avail` with 0x11 while 0x54 is in flight → only 0x54 is transmitted. Asserting `rst` mid-frame → `tx_serial`=1 and `tx_active`=0 the next cycle, with no `tx_done` pulse.
6. DATA_BITS=7, parity none, STOP_BITS=2, loopback, two back-to-back words 0x7F then 0x00 → two `rx_data_avail` pulses 640±4 cycles apart, both error flags 0.
